// File: rtl/diag_pkg.sv
// Shared types and ASCII helpers for the diagnostic command receiver.
// Covers the byte-level UART receiver and the override-command parser.
package diag_pkg;

   localparam logic [7:0] ASC_A  = 8'h41;
   localparam logic [7:0] ASC_CR = 8'h0D;
   localparam logic [7:0] ASC_0  = 8'h30;
   localparam logic [7:0] ASC_3  = 8'h33;
   localparam logic [7:0] ASC_9  = 8'h39;
   localparam logic [7:0] ASC_UF = 8'h46;
   localparam logic [7:0] ASC_LA = 8'h61;
   localparam logic [7:0] ASC_LF = 8'h66;

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

   typedef enum logic [2:0] {P_IDLE, P_CH, P_H2, P_H1, P_H0, P_END} parse_state_t;

   typedef struct packed {
      logic       valid;
      logic [3:0] nib;
   } hex_t;

   // Digits map straight from the low nibble; letters need +9 ('A' = 0x41 -> 0xA).
   function automatic hex_t hex_to_nibble(input logic [7:0] c);
      hex_t h;
      h.valid = 1'b0;
      h.nib   = 4'h0;
      if (c >= ASC_0 && c <= ASC_9) begin
         h.valid = 1'b1;
         h.nib   = c[3:0];
      end else if ((c >= ASC_A && c <= ASC_UF) || (c >= ASC_LA && c <= ASC_LF)) begin
         h.valid = 1'b1;
         h.nib   = c[3:0] + 4'd9;
      end
      return h;
   endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver with 16x oversampling and a majority vote of the samples at phases 7/8/9.
// A held-low line reports one framing error, then waits in BREAK until the line goes idle.
module uart_rx_core
   import diag_pkg::*;
#(
   parameter int OSR_DIV = 26
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frm_err
);

   localparam int PW = (OSR_DIV > 1) ? $clog2(OSR_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(OSR_DIV - 1);

   logic          rx_meta;
   logic          rxs;
   logic [PW-1:0] presc;
   logic          tick;
   logic [3:0]    phase;
   logic          s7;
   logic          s8;
   logic          maj;
   logic [7:0]    shreg;
   logic [2:0]    bit_idx;
   rx_state_t     state;
   rx_state_t     state_nxt;
   logic          clr_phase;
   logic          bit_clr;
   logic          bit_inc;
   logic          shift_en;
   logic          load_data;
   logic          frame_bad;

   assign tick = (presc == PRESC_MAX);
   assign maj  = (s7 & s8) | (s7 & rxs) | (s8 & rxs);

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= rx;
         rxs     <= rx_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || tick) presc <= '0;
      else               presc <= presc + 1'b1;
   end

   // The phase is re-zeroed on the start edge so phases 7..9 straddle each bit centre.
   always_ff @(posedge clk) begin
      if (reset) begin
         phase <= 4'd0;
         s7    <= 1'b1;
         s8    <= 1'b1;
      end else if (tick) begin
         phase <= clr_phase ? 4'd0 : phase + 4'd1;
         if (phase == 4'd7) s7 <= rxs;
         if (phase == 4'd8) s8 <= rxs;
      end
   end

   always_comb begin
      state_nxt = state;
      clr_phase = 1'b0;
      bit_clr   = 1'b0;
      bit_inc   = 1'b0;
      shift_en  = 1'b0;
      load_data = 1'b0;
      frame_bad = 1'b0;
      if (tick) begin
         case (state)
            IDLE: begin
               if (!rxs) begin
                  clr_phase = 1'b1;
                  state_nxt = START;
               end
            end
            START: begin
               if (phase == 4'd9 && maj) begin
                  state_nxt = IDLE;
               end else if (phase == 4'd15) begin
                  bit_clr   = 1'b1;
                  state_nxt = DATA;
               end
            end
            DATA: begin
               if (phase == 4'd9) shift_en = 1'b1;
               if (phase == 4'd15) begin
                  if (bit_idx == 3'd7) state_nxt = STOP;
                  else                 bit_inc   = 1'b1;
               end
            end
            STOP: begin
               if (phase == 4'd9) begin
                  if (maj) begin
                     load_data = 1'b1;
                     state_nxt = IDLE;
                  end else begin
                     frame_bad = 1'b1;
                     state_nxt = BREAK;
                  end
               end
            end
            BREAK: begin
               if (rxs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         bit_idx  <= 3'd0;
         shreg    <= 8'h00;
         rx_data  <= 8'h00;
         rx_valid <= 1'b0;
         frm_err  <= 1'b0;
      end else begin
         state    <= state_nxt;
         rx_valid <= load_data;
         frm_err  <= frame_bad;
         if (bit_clr)      bit_idx <= 3'd0;
         else if (bit_inc) bit_idx <= bit_idx + 3'd1;
         if (shift_en)  shreg   <= {maj, shreg[7:1]};
         if (load_data) rx_data <= shreg;
      end
   end

endmodule

// File: rtl/diag_cmd_rx.sv
// Diagnostic port receive side: UART byte receiver plus the "A<ch><hhh><CR>" override parser.
// The override outputs only change on a complete, well-formed command.
module diag_cmd_rx
   import diag_pkg::*;
#(
   parameter int CLK_HZ  = 48000000,
   parameter int BAUD    = 115200,
   parameter int OSR_DIV = CLK_HZ / (16 * BAUD)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   output logic        frm_err,
   output logic [1:0]  cmd_ch,
   output logic [11:0] cmd_val,
   output logic        cmd_stb,
   output logic        cmd_err
);

   parse_state_t pstate;
   parse_state_t pstate_nxt;
   logic [1:0]   ch_q;
   logic [1:0]   ch_nxt;
   logic [11:0]  val_q;
   logic [11:0]  val_nxt;
   logic         stb_nxt;
   logic         err_nxt;
   hex_t         hx;

   uart_rx_core #(
      .OSR_DIV (OSR_DIV)
   ) u_rx (
      .clk      (clk),
      .reset    (reset),
      .rx       (rx),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .frm_err  (frm_err)
   );

   assign hx = hex_to_nibble(rx_data);

   // Any bad byte aborts; an 'A' where a channel or CR was expected restarts a new command.
   always_comb begin
      pstate_nxt = pstate;
      ch_nxt     = ch_q;
      val_nxt    = val_q;
      stb_nxt    = 1'b0;
      err_nxt    = 1'b0;
      if (frm_err) begin
         if (pstate != P_IDLE) begin
            err_nxt    = 1'b1;
            pstate_nxt = P_IDLE;
         end
      end else if (rx_valid) begin
         case (pstate)
            P_IDLE: begin
               if (rx_data == ASC_A) pstate_nxt = P_CH;
            end
            P_CH: begin
               if (rx_data >= ASC_0 && rx_data <= ASC_3) begin
                  ch_nxt     = rx_data[1:0];
                  pstate_nxt = P_H2;
               end else begin
                  err_nxt = 1'b1;
                  if (rx_data == ASC_A) pstate_nxt = P_CH;
                  else                  pstate_nxt = P_IDLE;
               end
            end
            P_H2, P_H1, P_H0: begin
               if (hx.valid) begin
                  case (pstate)
                     P_H2: begin
                        val_nxt[11:8] = hx.nib;
                        pstate_nxt    = P_H1;
                     end
                     P_H1: begin
                        val_nxt[7:4] = hx.nib;
                        pstate_nxt   = P_H0;
                     end
                     default: begin
                        val_nxt[3:0] = hx.nib;
                        pstate_nxt   = P_END;
                     end
                  endcase
               end else begin
                  err_nxt    = 1'b1;
                  pstate_nxt = P_IDLE;
               end
            end
            P_END: begin
               if (rx_data == ASC_CR) begin
                  stb_nxt    = 1'b1;
                  pstate_nxt = P_IDLE;
               end else begin
                  err_nxt = 1'b1;
                  if (rx_data == ASC_A) pstate_nxt = P_CH;
                  else                  pstate_nxt = P_IDLE;
               end
            end
            default: pstate_nxt = P_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pstate  <= P_IDLE;
         ch_q    <= 2'd0;
         val_q   <= 12'h000;
         cmd_ch  <= 2'd0;
         cmd_val <= 12'h000;
         cmd_stb <= 1'b0;
         cmd_err <= 1'b0;
      end else begin
         pstate  <= pstate_nxt;
         ch_q    <= ch_nxt;
         val_q   <= val_nxt;
         cmd_stb <= stb_nxt;
         cmd_err <= err_nxt;
         if (stb_nxt) begin
            cmd_ch  <= ch_q;
            cmd_val <= val_q;
         end
      end
   end

endmodule

// File: tb/tb_diag_cmd_rx.sv
// Directed bench for diag_cmd_rx: serial frames in, byte/command pulses counted and compared.
// Runs at a reduced clock so each bit is 96 clocks and the whole sequence stays short.
module tb_diag_cmd_rx;

   localparam int CLK_HZ = 12000000;
   localparam int BAUD   = 115200;
   localparam int OSR    = CLK_HZ / (16 * BAUD);
   localparam int BIT    = 16 * OSR;
   localparam int LAT_MIN = 154 * OSR;
   localparam int LAT_MAX = 156 * OSR;

   logic        clk = 1'b0;
   logic        reset;
   logic        rx;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        frm_err;
   logic [1:0]  cmd_ch;
   logic [11:0] cmd_val;
   logic        cmd_stb;
   logic        cmd_err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int start_cyc = 0;
   int valid_cyc = 0;
   int rv_cnt = 0;
   int frm_cnt = 0;
   int stb_cnt = 0;
   int err_cnt = 0;
   int back2back = 0;
   logic [3:0] prev_pulses = 4'b0000;

   int r0, f0, s0, e0, lat;

   diag_cmd_rx #(
      .CLK_HZ (CLK_HZ),
      .BAUD   (BAUD)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .rx       (rx),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .frm_err  (frm_err),
      .cmd_ch   (cmd_ch),
      .cmd_val  (cmd_val),
      .cmd_stb  (cmd_stb),
      .cmd_err  (cmd_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse counting and back-to-back detection, sampled mid-cycle.
   always @(negedge clk) begin
      if (rx_valid) begin
         rv_cnt    <= rv_cnt + 1;
         valid_cyc <= cyc;
      end
      if (frm_err) frm_cnt <= frm_cnt + 1;
      if (cmd_stb) stb_cnt <= stb_cnt + 1;
      if (cmd_err) err_cnt <= err_cnt + 1;
      if (|(prev_pulses & {rx_valid, frm_err, cmd_stb, cmd_err})) back2back <= back2back + 1;
      prev_pulses <= {rx_valid, frm_err, cmd_stb, cmd_err};
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
      @(posedge clk); #1;
      rx = 1'b0;
      start_cyc = cyc;
      repeat (BIT) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (BIT) @(posedge clk);
         #1;
      end
      rx = stop_bit;
      repeat (BIT) @(posedge clk);
      #1;
   endtask

   task automatic sendString(input string s);
      for (int i = 0; i < s.len(); i++) applyStimulus(s[i], 1'b1);
   endtask

   initial begin
      logic [7:0] partial;
      reset = 1'b1;
      rx    = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("reset_rx_data", 32'(rx_data), 32'h00);
      checkOutput("reset_cmd_ch", 32'(cmd_ch), 32'h0);
      checkOutput("reset_cmd_val", 32'(cmd_val), 32'h000);
      checkOutput("reset_pulses", 32'({rx_valid, frm_err, cmd_stb, cmd_err}), 32'h0);
      reset = 1'b0;
      repeat (BIT) @(posedge clk);

      r0 = rv_cnt; f0 = frm_cnt;
      applyStimulus(8'h55, 1'b1);
      lat = valid_cyc - start_cyc;
      checkOutput("byte_valid_count", 32'(rv_cnt - r0), 32'd1);
      checkOutput("byte_data", 32'(rx_data), 32'h55);
      checkOutput("byte_latency_in_window", 32'(lat >= LAT_MIN && lat <= LAT_MAX), 32'd1);
      checkOutput("byte_no_frm_err", 32'(frm_cnt - f0), 32'd0);

      s0 = stb_cnt; e0 = err_cnt;
      sendString("A27FF\r");
      checkOutput("cmd1_stb_count", 32'(stb_cnt - s0), 32'd1);
      checkOutput("cmd1_err_count", 32'(err_cnt - e0), 32'd0);
      checkOutput("cmd1_ch", 32'(cmd_ch), 32'd2);
      checkOutput("cmd1_val", 32'(cmd_val), 32'h7FF);

      s0 = stb_cnt; e0 = err_cnt;
      sendString("A3abc\n");
      checkOutput("lf_abort_err", 32'(err_cnt - e0), 32'd1);
      sendString("\r");
      checkOutput("cr_idle_err", 32'(err_cnt - e0), 32'd1);
      checkOutput("cr_idle_stb", 32'(stb_cnt - s0), 32'd0);
      checkOutput("abort_keeps_val", 32'(cmd_val), 32'h7FF);
      checkOutput("abort_keeps_ch", 32'(cmd_ch), 32'd2);

      e0 = err_cnt;
      sendString("A4");
      checkOutput("bad_ch_err", 32'(err_cnt - e0), 32'd1);
      e0 = err_cnt;
      sendString("A1AAA");
      checkOutput("hex_A_no_err", 32'(err_cnt - e0), 32'd0);
      sendString("A");
      checkOutput("end_A_err", 32'(err_cnt - e0), 32'd1);
      s0 = stb_cnt; e0 = err_cnt;
      sendString("0123\r");
      checkOutput("resync_stb", 32'(stb_cnt - s0), 32'd1);
      checkOutput("resync_err", 32'(err_cnt - e0), 32'd0);
      checkOutput("resync_ch", 32'(cmd_ch), 32'd0);
      checkOutput("resync_val", 32'(cmd_val), 32'h123);

      r0 = rv_cnt; f0 = frm_cnt;
      @(posedge clk); #1;
      rx = 1'b0;
      repeat (BIT / 4) @(posedge clk);
      #1;
      rx = 1'b1;
      repeat (3 * BIT) @(posedge clk);
      checkOutput("glitch_no_valid", 32'(rv_cnt - r0), 32'd0);
      checkOutput("glitch_no_frm", 32'(frm_cnt - f0), 32'd0);
      applyStimulus(8'hA5, 1'b1);
      checkOutput("post_glitch_data", 32'(rx_data), 32'hA5);
      checkOutput("post_glitch_count", 32'(rv_cnt - r0), 32'd1);

      sendString("A2");
      r0 = rv_cnt; f0 = frm_cnt; e0 = err_cnt;
      applyStimulus(8'h00, 1'b0);
      repeat (3 * BIT) @(posedge clk);
      #1;
      rx = 1'b1;
      repeat (2 * BIT) @(posedge clk);
      checkOutput("break_frm_count", 32'(frm_cnt - f0), 32'd1);
      checkOutput("break_no_valid", 32'(rv_cnt - r0), 32'd0);
      checkOutput("break_cmd_err", 32'(err_cnt - e0), 32'd1);
      checkOutput("break_keeps_data", 32'(rx_data), 32'h32);
      applyStimulus(8'h41, 1'b1);
      checkOutput("post_break_data", 32'(rx_data), 32'h41);
      checkOutput("post_break_count", 32'(rv_cnt - r0), 32'd1);
      checkOutput("post_break_frm", 32'(frm_cnt - f0), 32'd1);

      partial = 8'h31;
      @(posedge clk); #1;
      rx = 1'b0;
      repeat (BIT) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         rx = partial[i];
         repeat (BIT) @(posedge clk);
         #1;
      end
      rx = partial[4];
      repeat (BIT / 2) @(posedge clk);
      #1;
      reset = 1'b1;
      rx    = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("midframe_reset_data", 32'(rx_data), 32'h00);
      checkOutput("midframe_reset_ch", 32'(cmd_ch), 32'd0);
      checkOutput("midframe_reset_val", 32'(cmd_val), 32'h000);
      checkOutput("midframe_reset_pulses", 32'({rx_valid, frm_err, cmd_stb, cmd_err}), 32'h0);
      reset = 1'b0;
      r0 = rv_cnt;
      repeat (12 * BIT) @(posedge clk);
      checkOutput("midframe_discarded", 32'(rv_cnt - r0), 32'd0);
      s0 = stb_cnt; e0 = err_cnt;
      sendString("A1000\r");
      checkOutput("after_reset_stb", 32'(stb_cnt - s0), 32'd1);
      checkOutput("after_reset_err", 32'(err_cnt - e0), 32'd0);
      checkOutput("after_reset_ch", 32'(cmd_ch), 32'd1);
      checkOutput("after_reset_val", 32'(cmd_val), 32'h000);

      repeat (4) @(posedge clk);
      checkOutput("no_back_to_back_pulses", 32'(back2back), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
